// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default constants for the SRAM read arbiter
//
// Purpose : FSM state and port-owner encodings, default parameter values,
//           and a width helper for the small internal counters.
// Ports   : none (package).

package sram_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   typedef enum logic [0:0] {
      PORT_A = 1'b0,
      PORT_C = 1'b1
   } port_t;

   localparam int DEF_ADDR_W        = 20;
   localparam int DEF_DATA_W        = 16;
   localparam int DEF_READ_CYCLES   = 2;
   localparam int DEF_MAX_HI_STREAK = 4;

   // Bits needed to hold the values 0..max_val (at least one bit).
   function automatic int count_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sram_port_capture.sv
// rtl/sram_port_capture.sv - per-port read-data capture register with valid pulse
//
// Purpose : Latches the SRAM data bus when the arbiter closes a read for
//           this port and raises a one-cycle valid alongside the new word.
//           The data register holds its value between captures.
// Ports   :
//   Clk      in   system clock
//   reset    in   synchronous, active-high; clears data and valid
//   capture  in   one-cycle strobe: sample din this edge
//   din      in   DATA_W SRAM data bus
//   data_o   out  DATA_W last captured word
//   valid_o  out  one-cycle pulse in the cycle data_o is updated

module sram_port_capture
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              capture,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = capture;
      if (capture) begin
         data_d = din;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/sram_read_arbiter.sv
// rtl/sram_read_arbiter.sv - two-port read arbiter for the shared async board SRAM
//
// Purpose : Shares one asynchronous 16-bit SRAM between the audio sample
//           streamer (port A, high priority) and the chart/arrow-data reader
//           (port C, low priority). Owns all SRAM control pins, holds each
//           read for READ_CYCLES cycles, returns captured data per port and
//           forces a C grant after MAX_HI_STREAK consecutive A grants made
//           while C was waiting.
// Ports   :
//   Clk               in   system clock (50 MHz)
//   reset             in   synchronous, active-high
//   a_req / c_req     in   read request, held with address until ack
//   a_addr / c_addr   in   ADDR_W word address
//   a_ack / c_ack     out  one-cycle pulse: address latched, request accepted
//   a_valid / c_valid out  one-cycle pulse: port data updated
//   a_data / c_data   out  DATA_W last word read for the port
//   SRAM_DQ           in   DATA_W SRAM data bus
//   SRAM_ADDR         out  ADDR_W registered SRAM address
//   SRAM_CE_N/OE_N/UB_N/LB_N out active-low registered controls
//   SRAM_WE_N         out  tied high, the SRAM is never written
//   busy              out  high while a read is in progress

module sram_read_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int READ_CYCLES   = DEF_READ_CYCLES,
   parameter int MAX_HI_STREAK = DEF_MAX_HI_STREAK
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ack,
   output logic              a_valid,
   output logic [DATA_W-1:0] a_data,
   input  logic              c_req,
   input  logic [ADDR_W-1:0] c_addr,
   output logic              c_ack,
   output logic              c_valid,
   output logic [DATA_W-1:0] c_data,
   input  logic [DATA_W-1:0] SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_WE_N,
   output logic              busy
);

   localparam int CNT_W = count_width(READ_CYCLES);
   localparam int STK_W = count_width(MAX_HI_STREAK);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(READ_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
   localparam logic [STK_W-1:0] STK_MAX   = STK_W'(MAX_HI_STREAK);

   state_t            state_q,  state_d;
   port_t             owner_q,  owner_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic              ctrl_n_q, ctrl_n_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [STK_W-1:0]  streak_q, streak_d;
   logic              a_ack_q,  a_ack_d;
   logic              c_ack_q,  c_ack_d;

   logic              pick_a;
   logic              pick_c;
   logic              cap_a;
   logic              cap_c;

   // A wins unless C has already been passed over MAX_HI_STREAK times.
   assign pick_a = a_req && !(c_req && (streak_q == STK_MAX));
   assign pick_c = !pick_a && c_req;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      ctrl_n_d = ctrl_n_q;
      cnt_d    = cnt_q;
      streak_d = streak_q;
      a_ack_d  = 1'b0;
      c_ack_d  = 1'b0;
      cap_a    = 1'b0;
      cap_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_a) begin
               state_d  = READ;
               owner_d  = PORT_A;
               addr_d   = a_addr;
               ctrl_n_d = 1'b0;
               cnt_d    = CNT_FIRST;
               a_ack_d  = 1'b1;
               // Only A grants that bypass a waiting C count toward starvation.
               if (c_req && (streak_q != STK_MAX)) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (pick_c) begin
               state_d  = READ;
               owner_d  = PORT_C;
               addr_d   = c_addr;
               ctrl_n_d = 1'b0;
               cnt_d    = CNT_FIRST;
               c_ack_d  = 1'b1;
               streak_d = '0;
            end
         end

         READ: begin
            if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // Data has been stable for READ_CYCLES cycles; sample and release.
               cap_a    = (owner_q == PORT_A);
               cap_c    = (owner_q == PORT_C);
               ctrl_n_d = 1'b1;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            ctrl_n_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= PORT_A;
         addr_q   <= '0;
         ctrl_n_q <= 1'b1;
         cnt_q    <= '0;
         streak_q <= '0;
         a_ack_q  <= 1'b0;
         c_ack_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         ctrl_n_q <= ctrl_n_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
         a_ack_q  <= a_ack_d;
         c_ack_q  <= c_ack_d;
      end
   end

   sram_port_capture #(
      .DATA_W (DATA_W)
   ) u_cap_a (
      .Clk     (Clk),
      .reset   (reset),
      .capture (cap_a),
      .din     (SRAM_DQ),
      .data_o  (a_data),
      .valid_o (a_valid)
   );

   sram_port_capture #(
      .DATA_W (DATA_W)
   ) u_cap_c (
      .Clk     (Clk),
      .reset   (reset),
      .capture (cap_c),
      .din     (SRAM_DQ),
      .data_o  (c_data),
      .valid_o (c_valid)
   );

   assign a_ack     = a_ack_q;
   assign c_ack     = c_ack_q;
   assign SRAM_ADDR = addr_q;
   // CE, OE and both byte lanes move together: every access is a full-word read.
   assign SRAM_CE_N = ctrl_n_q;
   assign SRAM_OE_N = ctrl_n_q;
   assign SRAM_UB_N = ctrl_n_q;
   assign SRAM_LB_N = ctrl_n_q;
   assign SRAM_WE_N = 1'b1;
   assign busy      = (state_q == READ);

endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb/tb_sram_read_arbiter.sv - directed self-checking bench for sram_read_arbiter

module tb_sram_read_arbiter;

   logic        Clk = 1'b0;
   logic        reset;
   logic        a_req, c_req;
   logic [19:0] a_addr, c_addr;
   logic        a_ack, a_valid, c_ack, c_valid;
   logic [15:0] a_data, c_data;
   logic [15:0] SRAM_DQ;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic pend = 1'b0;
   logic pend_c = 1'b0;

   always #10 Clk = ~Clk;

   function automatic logic [15:0] model(input logic [19:0] ad);
      case (ad)
         20'h00010: return 16'hBEEF;
         20'h00020: return 16'h2020;
         20'h00030: return 16'h3030;
         20'h00040: return 16'h4040;
         20'h00200: return 16'h1234;
         20'hFFFFF: return 16'hA5A5;
         default:   return 16'hDEAD;
      endcase
   endfunction

   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? model(SRAM_ADDR) : 16'h0000;

   sram_read_arbiter dut (
      .Clk       (Clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_addr    (a_addr),
      .a_ack     (a_ack),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .c_req     (c_req),
      .c_addr    (c_addr),
      .c_ack     (c_ack),
      .c_valid   (c_valid),
      .c_data    (c_data),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N),
      .SRAM_WE_N (SRAM_WE_N),
      .busy      (busy)
   );

   // Every-cycle invariants: WE_N high, at most one ack, valid only for the acked port.
   always @(negedge Clk) begin
      if (mon_en) begin
         checks++;
         if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL mon_we_n got %b exp 1", SRAM_WE_N); end
         checks++;
         if ((a_ack & c_ack) !== 1'b0) begin errors++; $display("FAIL mon_two_acks got a=%b c=%b", a_ack, c_ack); end
         if (a_valid || c_valid) begin
            checks++;
            if (!(pend && ((a_valid && !c_valid && !pend_c) || (c_valid && !a_valid && pend_c)))) begin
               errors++;
               $display("FAIL mon_valid_owner got a_valid=%b c_valid=%b exp pend=%b owner_c=%b", a_valid, c_valid, pend, pend_c);
            end
            pend = 1'b0;
         end else if (!busy) begin
            pend = 1'b0;
         end
         if (a_ack) begin pend = 1'b1; pend_c = 1'b0; end
         if (c_ack) begin pend = 1'b1; pend_c = 1'b1; end
      end
   end

   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; a_req = 1'b0; c_req = 1'b0; a_addr = '0; c_addr = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++; if (SRAM_CE_N !== 1'b1) begin errors++; $display("FAIL rst_ce_n got %b exp 1", SRAM_CE_N); end
      checks++; if ({SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N} !== 4'hF) begin errors++; $display("FAIL rst_ctrl got %b exp 1111", {SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}); end
      checks++; if (SRAM_ADDR !== 20'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000", SRAM_ADDR); end
      checks++; if ({a_data, c_data} !== 32'h0) begin errors++; $display("FAIL rst_data got %h %h exp 0 0", a_data, c_data); end
      checks++; if ({a_ack, a_valid, c_ack, c_valid, busy} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {a_ack, a_valid, c_ack, c_valid, busy}); end
      mon_en = 1'b1;
   endtask

   task automatic test_single_a();
      a_addr = 20'h00010; a_req = 1'b1;
      checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL s1_ack_c0 got %b exp 0", a_ack); end
      tick();
      checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL s1_ack_c1 got %b exp 1", a_ack); end
      checks++; if (SRAM_ADDR !== 20'h00010) begin errors++; $display("FAIL s1_addr_c1 got %h exp 00010", SRAM_ADDR); end
      checks++; if ({SRAM_CE_N, SRAM_OE_N, busy} !== 3'b001) begin errors++; $display("FAIL s1_ctrl_c1 got %b exp 001", {SRAM_CE_N, SRAM_OE_N, busy}); end
      a_req = 1'b0; a_addr = 20'h00055;
      tick();
      checks++; if ({a_ack, a_valid} !== 2'b00) begin errors++; $display("FAIL s1_pulse_c2 got %b exp 00", {a_ack, a_valid}); end
      checks++; if (SRAM_ADDR !== 20'h00010) begin errors++; $display("FAIL s1_addr_c2 got %h exp 00010", SRAM_ADDR); end
      checks++; if ({SRAM_CE_N, SRAM_OE_N} !== 2'b00) begin errors++; $display("FAIL s1_ctrl_c2 got %b exp 00", {SRAM_CE_N, SRAM_OE_N}); end
      tick();
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL s1_valid_c3 got %b exp 1", a_valid); end
      checks++; if (a_data !== 16'hBEEF) begin errors++; $display("FAIL s1_data_c3 got %h exp beef", a_data); end
      checks++; if ({SRAM_CE_N, SRAM_OE_N, busy} !== 3'b110) begin errors++; $display("FAIL s1_ctrl_c3 got %b exp 110", {SRAM_CE_N, SRAM_OE_N, busy}); end
      tick();
      checks++; if ({a_valid, a_ack} !== 2'b00) begin errors++; $display("FAIL s1_pulse_c4 got %b exp 00", {a_valid, a_ack}); end
      checks++; if (a_data !== 16'hBEEF) begin errors++; $display("FAIL s1_hold_c4 got %h exp beef", a_data); end
   endtask

   task automatic test_simultaneous();
      a_addr = 20'h00020; c_addr = 20'h00200; a_req = 1'b1; c_req = 1'b1;
      tick();
      checks++; if ({a_ack, c_ack} !== 2'b10) begin errors++; $display("FAIL s2_ack_c1 got %b exp 10", {a_ack, c_ack}); end
      a_req = 1'b0;
      tick(); tick();
      checks++; if ({a_valid, c_valid} !== 2'b10) begin errors++; $display("FAIL s2_valid_c3 got %b exp 10", {a_valid, c_valid}); end
      checks++; if (a_data !== 16'h2020) begin errors++; $display("FAIL s2_adata_c3 got %h exp 2020", a_data); end
      tick();
      checks++; if ({a_ack, c_ack} !== 2'b01) begin errors++; $display("FAIL s2_ack_c4 got %b exp 01", {a_ack, c_ack}); end
      checks++; if (SRAM_ADDR !== 20'h00200) begin errors++; $display("FAIL s2_addr_c4 got %h exp 00200", SRAM_ADDR); end
      c_req = 1'b0;
      tick();
      checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL s2_cvalid_c5 got %b exp 0", c_valid); end
      tick();
      checks++; if ({a_valid, c_valid} !== 2'b01) begin errors++; $display("FAIL s2_valid_c6 got %b exp 01", {a_valid, c_valid}); end
      checks++; if ({c_data, a_data} !== 32'h1234_2020) begin errors++; $display("FAIL s2_data_c6 got %h %h exp 1234 2020", c_data, a_data); end
      tick();
   endtask

   task automatic test_streak();
      logic [9:0] exp_c;
      int n;
      int first;
      exp_c = 10'h210;
      n = 0;
      first = 0;
      a_addr = 20'h00030; c_addr = 20'h00040; a_req = 1'b1; c_req = 1'b1;
      for (int cyc = 1; cyc <= 40 && n < 10; cyc++) begin
         tick();
         if (a_ack || c_ack) begin
            if (n == 0) first = cyc;
            checks++;
            if (c_ack !== exp_c[n]) begin errors++; $display("FAIL s3_grant_%0d got c_ack=%b exp %b", n, c_ack, exp_c[n]); end
            checks++;
            if (cyc != first + 3 * n) begin errors++; $display("FAIL s3_spacing_%0d got cycle %0d exp %0d", n, cyc, first + 3 * n); end
            n++;
            if (n == 10) begin a_req = 1'b0; c_req = 1'b0; end
         end
      end
      checks++; if (n != 10) begin errors++; $display("FAIL s3_grant_count got %0d exp 10", n); end
      checks++; if (first != 1) begin errors++; $display("FAIL s3_first_ack got cycle %0d exp 1", first); end
      a_req = 1'b0; c_req = 1'b0;
      repeat (3) tick();
      checks++; if ({a_data, c_data} !== 32'h3030_4040) begin errors++; $display("FAIL s3_data got %h %h exp 3030 4040", a_data, c_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s3_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_reset_mid_read();
      a_addr = 20'h00010; a_req = 1'b1;
      tick();
      checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL s4_ack_c1 got %b exp 1", a_ack); end
      a_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      checks++; if ({SRAM_CE_N, SRAM_OE_N, busy, a_valid} !== 4'b1100) begin errors++; $display("FAIL s4_abort_c3 got %b exp 1100", {SRAM_CE_N, SRAM_OE_N, busy, a_valid}); end
      checks++; if ({a_data, c_data} !== 32'h0) begin errors++; $display("FAIL s4_cleared_c3 got %h %h exp 0 0", a_data, c_data); end
      reset = 1'b0;
      tick();
      checks++; if ({a_valid, a_ack} !== 2'b00) begin errors++; $display("FAIL s4_no_valid_c4 got %b exp 00", {a_valid, a_ack}); end
      a_addr = 20'h00010; a_req = 1'b1;
      tick();
      checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL s4_reack got %b exp 1", a_ack); end
      a_req = 1'b0;
      tick(); tick();
      checks++; if ({a_valid, a_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL s4_reread got %b %h exp 1 beef", a_valid, a_data); end
      tick();
   endtask

   task automatic test_c_only();
      c_addr = 20'hFFFFF; c_req = 1'b1;
      tick();
      checks++; if ({a_ack, c_ack} !== 2'b01) begin errors++; $display("FAIL s5_ack_c1 got %b exp 01", {a_ack, c_ack}); end
      checks++; if (SRAM_ADDR !== 20'hFFFFF) begin errors++; $display("FAIL s5_addr_c1 got %h exp fffff", SRAM_ADDR); end
      c_req = 1'b0;
      tick();
      checks++; if ({a_ack, a_valid, c_valid} !== 3'b000) begin errors++; $display("FAIL s5_quiet_c2 got %b exp 000", {a_ack, a_valid, c_valid}); end
      tick();
      checks++; if ({a_valid, c_valid} !== 2'b01) begin errors++; $display("FAIL s5_valid_c3 got %b exp 01", {a_valid, c_valid}); end
      checks++; if (c_data !== 16'hA5A5) begin errors++; $display("FAIL s5_cdata_c3 got %h exp a5a5", c_data); end
      checks++; if (a_data !== 16'hBEEF) begin errors++; $display("FAIL s5_adata_hold got %h exp beef", a_data); end
      tick();
      checks++; if ({a_ack, a_valid, c_ack, c_valid} !== 4'b0000) begin errors++; $display("FAIL s5_quiet_c4 got %b exp 0000", {a_ack, a_valid, c_ack, c_valid}); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_a();
      test_simultaneous();
      test_streak();
      test_reset_mid_read();
      test_c_only();
      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares the single async 16-bit board SRAM between two read-only requesters.
- Port A is the audio sample streamer: high priority, 48 kHz cadence.
- Port C is the chart/arrow-data reader that feeds arrow scheduling: low priority.
- Owns every SRAM control pin, sequences multi-cycle reads, returns captured data per port, and bounds starvation of port C.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- READ_CYCLES, 2, cycles CE/OE are held low before data capture (>=1).
- MAX_HI_STREAK, 4, max consecutive port-A grants while C is pending (>=1).

Ports:
- Clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- a_req  in  1  audio read request; hold with a_addr until a_ack.
- a_addr  in  ADDR_W  audio word address.
- a_ack  out  1  one-cycle pulse: a_addr latched, request accepted.
- a_valid  out  1  one-cycle pulse: a_data updated.
- a_data  out  DATA_W  last word read for A; holds between valids.
- c_req, c_addr, c_ack, c_valid, c_data: same meanings for chart port C.
- SRAM_DQ  in  DATA_W  SRAM data bus (read-only use).
- SRAM_ADDR  out  ADDR_W  registered address.
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out  1  active-low, registered.
- SRAM_WE_N  out  1  constant 1.
- busy  out  1  high while state is READ.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock Clk. All outputs are registered.
- Reset values:
  - state IDLE.
  - CE_N/OE_N/UB_N/LB_N = 1; WE_N = 1.
  - SRAM_ADDR = 0; a_data = c_data = 0.
  - ack/valid = 0; busy = 0; streak = 0.
- States: IDLE and READ. No other states.
- IDLE:
  - Evaluate requests at each edge.
  - Winner = A if a_req and not (c_req and streak == MAX_HI_STREAK); else C if c_req; else stay IDLE.
  - On a grant:
    - state <= READ; SRAM_ADDR <= winner addr; owner <= winner.
    - winner's ack <= 1 for one cycle; cnt <= 1.
    - CE_N/OE_N/UB_N/LB_N <= 0.
- Streak rules:
  - A grant while c_req is high: streak++, saturating at MAX_HI_STREAK.
  - A grant while c_req is low: streak unchanged.
  - Any C grant: streak <= 0.
- READ:
  - Hold SRAM_ADDR and control pins.
  - If cnt < READ_CYCLES: cnt++.
  - Else, at that edge:
    - owner data <= SRAM_DQ; owner valid <= 1.
    - controls <= 1; state <= IDLE.
- Timing, with the first grant edge closing cycle 0:
  - ack is high in cycle 1.
  - READ occupies cycles 1..READ_CYCLES.
  - valid is high in cycle READ_CYCLES+1, which is also an IDLE cycle.
  - Latency req->valid = READ_CYCLES+1 cycles.
  - Max throughput: one read per READ_CYCLES+1 cycles.
- Handshake:
  - The requester drops req in the cycle after seeing ack.
  - req still high in an IDLE cycle is a new request, even if it is the same address.
  - Requests arriving during READ wait. No queueing beyond the req level.
- Address changes on a_addr/c_addr after ack have no effect on the current read.
- The non-owner port sees no ack/valid activity.
- Simultaneous a_req and c_req in IDLE are resolved by the priority rule above.
- Reset mid-READ:
  - Aborts the read and returns to reset values next cycle.
  - No valid is produced for the aborted read.
  - Captured data registers are cleared.
- SRAM_WE_N is never 0 under any condition.

Decomposition:
- Package sram_arb_pkg:
  - state_t enum {IDLE, READ}.
  - port_t enum {PORT_A, PORT_C}.
  - Default constants for ADDR_W, DATA_W, READ_CYCLES, MAX_HI_STREAK.
- Sub-module sram_port_capture, instantiated once per port:
  - Inputs: Clk, reset, capture, din.
  - Outputs: data register (holds value) and a one-cycle valid pulse.
- Arbitration, FSM and pin drive stay in sram_read_arbiter.

Test Plan:
All scenarios use READ_CYCLES=2, MAX_HI_STREAK=4, and an SRAM model with 1-cycle combinational read.
1. a_req=1, a_addr=0x00010 in cycle 0, model[0x10]=0xBEEF -> a_ack high in cycle 1 only; SRAM_ADDR=0x00010 and OE_N=CE_N=0 in cycles 1-2; a_valid in cycle 3 with a_data=0xBEEF; a_data holds 0xBEEF afterward.
2. a_req and c_req both rise in cycle 0 (c_addr=0x00200, model=0x1234) -> A acked cycle 1, A valid cycle 3; C acked cycle 4, c_valid cycle 6 with c_data=0x1234.
3. a_req and c_req held continuously -> grant sequence A,A,A,A,C,A,A,A,A,C; each grant 3 cycles apart; streak resets after each C.
4. reset pulsed during cycle 2 of an A read -> cycle 3: CE_N=OE_N=1, busy=0, a_valid=0, a_data=0; next request is served normally.
5. c_req alone with a_req low, c_addr=0xFFFFF, model=0xA5A5 -> c_ack cycle 1, c_valid cycle 3 with 0xA5A5; no activity on the A port.
6. Every cycle of all scenarios -> SRAM_WE_N=1; never more than one ack per cycle; valid only for the port previously acked.
